// File: rtl/ram64_arbiter_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// Sizes, FSM states and round-robin pointer encoding.
package ram64_arbiter_pkg;

  localparam int WORDSIZE  = 8;
  localparam int ADDR_SIZE = 6;
  localparam int RAM_DEPTH = 1 << ADDR_SIZE;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_t;

endpackage

// File: rtl/ram64_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: ports A and B
// plus the clear control.
interface ram64_arbiter_if #(
  parameter int WORDSIZE  = ram64_arbiter_pkg::WORDSIZE,
  parameter int ADDR_SIZE = ram64_arbiter_pkg::ADDR_SIZE
);

  logic                 a_req;
  logic                 a_we;
  logic [ADDR_SIZE-1:0] a_addr;
  logic [WORDSIZE-1:0]  a_wdata;
  logic                 a_gnt;
  logic                 a_rvalid;
  logic [WORDSIZE-1:0]  a_rdata;

  logic                 b_req;
  logic                 b_we;
  logic [ADDR_SIZE-1:0] b_addr;
  logic [WORDSIZE-1:0]  b_wdata;
  logic                 b_gnt;
  logic                 b_rvalid;
  logic [WORDSIZE-1:0]  b_rdata;

  logic                 clr_start;
  logic                 busy;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output clr_start,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  clr_start,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output busy
  );

endinterface

// File: rtl/ram64_arbiter_rr_arb2.sv
// Two-way round-robin selector; pointer picks the winner
// only when both requests are present.
module rr_arb2
  import ram64_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  ptr_t       pointer,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (pointer == PTR_A) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ram64_arbiter.sv
// Arbitrates a fetch port (A) and data port (B) onto one
// external RAM, with a 64-cycle zero-fill mode.
module ram64_arbiter #(
  parameter int WORDSIZE  = ram64_arbiter_pkg::WORDSIZE,
  parameter int ADDR_SIZE = ram64_arbiter_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  ram64_arbiter_if.slave       bus,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORDSIZE-1:0]  ram_data_in,
  output logic                 ram_write_en,
  input  logic [WORDSIZE-1:0]  ram_data_out
);

  localparam logic [ADDR_SIZE-1:0] CNT_LAST = '1;

  ram64_arbiter_pkg::state_t state;
  ram64_arbiter_pkg::state_t state_nx;
  ram64_arbiter_pkg::ptr_t   ptr;

  logic [ADDR_SIZE-1:0] cnt;
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic                 serve;
  logic                 clearing;
  logic                 a_rd;
  logic                 b_rd;

  // clr_start outranks both requesters in the same cycle
  assign serve = !rst && !bus.clr_start &&
                 (state == ram64_arbiter_pkg::S_IDLE);
  assign req   = {bus.b_req, bus.a_req} & {2{serve}};

  rr_arb2 u_rr (
    .req     (req),
    .pointer (ptr),
    .gnt     (gnt)
  );

  assign bus.a_gnt = gnt[0];
  assign bus.b_gnt = gnt[1];
  assign clearing  = !rst &&
                     (state == ram64_arbiter_pkg::S_CLEAR);
  assign bus.busy  = (state == ram64_arbiter_pkg::S_CLEAR);
  assign a_rd      = gnt[0] & ~bus.a_we;
  assign b_rd      = gnt[1] & ~bus.b_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ram64_arbiter_pkg::S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ram64_arbiter_pkg::S_IDLE:
        if (bus.clr_start)
          state_nx = ram64_arbiter_pkg::S_CLEAR;
      ram64_arbiter_pkg::S_CLEAR:
        if (cnt == CNT_LAST)
          state_nx = ram64_arbiter_pkg::S_IDLE;
      default:
        state_nx = ram64_arbiter_pkg::S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr     = '0;
    ram_data_in  = '0;
    ram_write_en = 1'b0;
    unique case (1'b1)
      clearing: begin
        ram_addr     = cnt;
        ram_write_en = 1'b1;
      end
      gnt[0]: begin
        ram_addr     = bus.a_addr;
        ram_data_in  = bus.a_wdata;
        ram_write_en = bus.a_we;
      end
      gnt[1]: begin
        ram_addr     = bus.b_addr;
        ram_data_in  = bus.b_wdata;
        ram_write_en = bus.b_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      ptr          <= ram64_arbiter_pkg::PTR_A;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      // counter wraps to zero on the last fill address
      if (state == ram64_arbiter_pkg::S_CLEAR)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (gnt[0])
        ptr <= ram64_arbiter_pkg::PTR_B;
      else if (gnt[1])
        ptr <= ram64_arbiter_pkg::PTR_A;
      bus.a_rvalid <= a_rd;
      bus.b_rvalid <= b_rd;
      if (a_rd) bus.a_rdata <= ram_data_out;
      if (b_rd) bus.b_rdata <= ram_data_out;
    end
  end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: external RAM, reference model,
// per-cycle compare and directed scenarios.
module tb_ram64_arbiter;
  import ram64_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram64_arbiter_if bus ();

  logic [ADDR_SIZE-1:0] ram_addr;
  logic [WORDSIZE-1:0]  ram_data_in;
  logic [WORDSIZE-1:0]  ram_data_out;
  logic                 ram_write_en;

  logic [WORDSIZE-1:0] mem [RAM_DEPTH];
  assign ram_data_out = mem[ram_addr];
  always @(posedge clk)
    if (ram_write_en) mem[ram_addr] <= ram_data_in;

  ram64_arbiter #(
    .WORDSIZE  (WORDSIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // reference model: memory image, clear progress, last winner
  logic [7:0] mmem [64];
  bit         m_clr;
  int         m_cnt;
  bit         m_last_b;
  bit         m_rva, m_rvb;
  logic [7:0] m_rda, m_rdb;

  function automatic void mgrant(output bit ga, output bit gb);
    ga = 0;
    gb = 0;
    if (!rst && !m_clr && !bus.clr_start) begin
      if (bus.a_req && bus.b_req) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = bus.a_req;
        gb = bus.b_req;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit ga, gb;
    if (rst) begin
      m_clr = 0; m_cnt = 0; m_last_b = 1;
      m_rva = 0; m_rvb = 0; m_rda = 0; m_rdb = 0;
    end else begin
      mgrant(ga, gb);
      m_rva = 0;
      m_rvb = 0;
      if (m_clr) begin
        mmem[m_cnt] = 8'h00;
        m_cnt++;
        if (m_cnt == 64) begin m_clr = 0; m_cnt = 0; end
      end else if (bus.clr_start) begin
        m_clr = 1;
        m_cnt = 0;
      end else if (ga) begin
        m_last_b = 0;
        if (bus.a_we) mmem[bus.a_addr] = bus.a_wdata;
        else begin m_rda = mmem[bus.a_addr]; m_rva = 1; end
      end else if (gb) begin
        m_last_b = 1;
        if (bus.b_we) mmem[bus.b_addr] = bus.b_wdata;
        else begin m_rdb = mmem[bus.b_addr]; m_rvb = 1; end
      end
    end
  end

  always @(negedge clk) begin
    bit ga, gb, we;
    logic [5:0] ad;
    logic [7:0] wd;
    mgrant(ga, gb);
    we = 0; ad = 0; wd = 0;
    if (!rst && m_clr) begin
      we = 1; ad = 6'(m_cnt);
    end else if (ga) begin
      we = bus.a_we; ad = bus.a_addr; wd = bus.a_wdata;
    end else if (gb) begin
      we = bus.b_we; ad = bus.b_addr; wd = bus.b_wdata;
    end
    chk("a_gnt", bus.a_gnt, ga);
    chk("b_gnt", bus.b_gnt, gb);
    chk("ram_write_en", ram_write_en, we);
    chk("ram_addr", ram_addr, ad);
    chk("ram_data_in", ram_data_in, wd);
    chk("busy", bus.busy, m_clr && !rst);
    chk("a_rvalid", bus.a_rvalid, m_rva);
    chk("b_rvalid", bus.b_rvalid, m_rvb);
    chk("a_rdata", bus.a_rdata, m_rda);
    chk("b_rdata", bus.b_rdata, m_rdb);
  end

  bit b_rv_seen;
  always @(negedge clk) if (bus.b_rvalid) b_rv_seen = 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    bus.clr_start = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic fill();
    for (int i = 0; i < 64; i++) begin
      step();
      bus.a_req = 1; bus.a_we = 1;
      bus.a_addr = 6'(i);
      bus.a_wdata = 8'(i) ^ 8'hA5;
    end
    step();
    idle();
  endtask

  task automatic rd_a(input logic [5:0] ad,
                      output logic [7:0] d);
    step();
    idle();
    bus.a_req = 1; bus.a_addr = ad;
    step();
    idle();
    chk("rd_rvalid", bus.a_rvalid, 1);
    d = bus.a_rdata;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      mmem[i] = 8'h00;
    end
    idle();
    bus.a_req = 1;
    #2;
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_we", ram_write_en, 0);
    idle();
    do_reset();
    #1;
    chk("rst_a_rdata", bus.a_rdata, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);

    step();
    bus.a_req = 1; bus.a_we = 1;
    bus.a_addr = 6'h10; bus.a_wdata = 8'h5A;
    #1 chk("wr_gnt", bus.a_gnt, 1);
    step();
    bus.a_we = 0;
    #1 chk("rd_gnt", bus.a_gnt, 1);
    chk("wr_no_rvalid", bus.a_rvalid, 0);
    step();
    idle();
    #1 chk("rd_rvalid_5a", bus.a_rvalid, 1);
    chk("rd_data_5a", bus.a_rdata, 8'h5A);
    step();
    chk("rvalid_pulse", bus.a_rvalid, 0);

    do_reset();
    step();
    bus.a_req = 1; bus.b_req = 1;
    bus.a_addr = 6'h01; bus.b_addr = 6'h02;
    #1 chk("rr1_a", bus.a_gnt, 1);
    chk("rr1_b", bus.b_gnt, 0);
    step();
    chk("rr2_b", bus.b_gnt, 1);
    chk("rr2_a", bus.a_gnt, 0);
    step();
    chk("rr3_a", bus.a_gnt, 1);
    step();
    idle();
    step();
    b_rv_seen = 0;

    bus.b_req = 1; bus.b_we = 1;
    bus.b_addr = 6'd63; bus.b_wdata = 8'h3C;
    step();
    idle();
    bus.a_req = 1; bus.a_addr = 6'd63;
    step();
    idle();
    chk("a63_rdata", bus.a_rdata, 8'h3C);
    step();
    chk("b_rvalid_never", b_rv_seen, 0);

    fill();
    bus.a_req = 1; bus.a_addr = 6'd5; bus.clr_start = 1;
    #1 chk("clr_no_gnt", bus.a_gnt, 0);
    step();
    bus.clr_start = 0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (n == 10) bus.clr_start = 1;
      if (n == 11) bus.clr_start = 0;
      step();
    end
    idle();
    chk("clr_busy_cycles", n, 64);
    rd_a(6'd0, d);  chk("clr_rd0", d, 8'h00);
    rd_a(6'd31, d); chk("clr_rd31", d, 8'h00);
    rd_a(6'd63, d); chk("clr_rd63", d, 8'h00);

    fill();
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    repeat (20) step();
    rst = 1;
    #1 chk("abort_busy", bus.busy, 0);
    chk("abort_we", ram_write_en, 0);
    step();
    rst = 0;
    rd_a(6'd0, d);  chk("abort_rd0", d, 8'h00);
    rd_a(6'd19, d); chk("abort_rd19", d, 8'h00);
    rd_a(6'd20, d); chk("abort_rd20", d, 8'hB1);
    rd_a(6'd40, d); chk("abort_rd40", d, 8'h8D);

    step();
    bus.a_req = 1; bus.a_addr = 6'd40;
    #2 rst = 1;
    step();
    chk("rstrd_rvalid", bus.a_rvalid, 0);
    chk("rstrd_rdata", bus.a_rdata, 8'h00);
    idle();
    step();
    rst = 0;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
